timer_share_sched: RTL

- Scheduler that shares one free-running-style N-bit up-counter between NREQ requesters, each needing a timed interval.
- Round-robin arbitration grants the counter to one requester at a time, loads that requester's interval length, runs the counter, and returns a one-cycle done pulse to the owner.
- Sits between the control blocks that need delays and the single shared counter datapath.

---
 rtl/timer_share_sched_if.sv | 16 +
 rtl/timer_share_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/timer_share_sched_if.sv
// Request/grant bundle between the delay-needing control blocks and the shared timer scheduler.
interface timer_share_sched_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      q;
  logic              tick;

  modport master (output req, len, input gnt, busy, done, q, tick);
  modport slave  (input req, len, output gnt, busy, done, q, tick);
endinterface

// File: rtl/timer_share_sched.sv
// Round-robin scheduler sharing one N-bit interval counter among NREQ requesters.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (adds the presc input).
module timer_share_sched #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned P    = 4
) (
  input logic clk,
  input logic reset,
`ifdef TIMER_PRESCALE_EN
  input logic [P-1:0] presc,
`endif
  timer_share_sched_if.slave bus
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_r, gnt_n;
  logic [N-1:0]    q_r, q_n;
  logic [N-1:0]    last_r, last_n;
  logic [PW-1:0]   ptr_r, ptr_n;
  logic [PW-1:0]   owner_r, owner_n;
  logic [P-1:0]    pcnt_r, pcnt_n;
  logic [P-1:0]    presc_r, presc_n;
  logic [P-1:0]    presc_sel;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            step;
  logic            owner_req;
  logic [N-1:0]    len_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = bus.len[g*N +: N];
  end

`ifdef TIMER_PRESCALE_EN
  assign presc_sel = presc;
`else
  // Divider held at zero so every RUN cycle is an enable cycle.
  assign presc_sel = '0;
`endif

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_r) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign step      = (pcnt_r == presc_r);
  assign owner_req = |(bus.req & gnt_r);

  always_comb begin
    state_n = state;
    gnt_n   = gnt_r;
    q_n     = q_r;
    last_n  = last_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    pcnt_n  = pcnt_r;
    presc_n = presc_r;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_RUN;
          gnt_n   = NREQ'(1) << win;
          owner_n = win;
          // len of 0 wraps to all-ones, giving the full 2**N count.
          last_n  = len_arr[win] - N'(1);
          q_n     = '0;
          pcnt_n  = '0;
          presc_n = presc_sel;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          q_n     = '0;
        end else if (step) begin
          pcnt_n = '0;
          if (q_r == last_r) state_n = S_DONE;
          else               q_n     = q_r + N'(1);
        end else begin
          pcnt_n = pcnt_r + P'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        q_n     = '0;
        ptr_n   = (owner_r == PW'(NREQ - 1)) ? '0 : owner_r + PW'(1);
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        q_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      gnt_r   <= '0;
      q_r     <= '0;
      last_r  <= '0;
      ptr_r   <= '0;
      owner_r <= '0;
      pcnt_r  <= '0;
      presc_r <= '0;
    end else begin
      state   <= state_n;
      gnt_r   <= gnt_n;
      q_r     <= q_n;
      last_r  <= last_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      pcnt_r  <= pcnt_n;
      presc_r <= presc_n;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.q    = q_r;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE) ? gnt_r : '0;
  assign bus.tick = (state == S_RUN) && step && (q_r == last_r);

endmodule
